// File: rtl/alu_issue_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sched_pkg
// Description : Shared widths, issue-entry type and wakeup tag compare for the
//               ALU issue scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_sched_pkg;

  localparam int NENT       = 8;
  localparam int LNENT      = 3;
  localparam int CNTRL_SIZE = 7;
  localparam int NCOMMIT    = 32;
  localparam int LNCOMMIT   = 5;
  localparam int VA_SZ      = 48;
  localparam int NWAKE      = 2;

  typedef logic [LNENT-1:0]    idx_t;
  typedef logic [LNENT:0]      cnt_t;
  typedef logic [LNCOMMIT-1:0] tag_t;

  typedef struct packed {
    logic [CNTRL_SIZE-1:0] control;
    tag_t                  rd;
    logic                  makes_rd;
    logic                  needs_rs2;
    tag_t                  rs1;
    tag_t                  rs2;
    logic                  rs1_rdy;
    logic                  rs2_rdy;
    logic [31:0]           immed;
    logic [VA_SZ-2:0]      pc;
  } entry_t;

  // True when any valid result bus, or the local fast-wake source, carries tag
  function automatic logic wake_hit(
    input tag_t                      tag,
    input logic [NWAKE-1:0]          wv,
    input logic [NWAKE*LNCOMMIT-1:0] wrd,
    input logic                      fv,
    input tag_t                      frd
  );
    logic hit;
    hit = fv && (frd == tag);
    for (int i = 0; i < NWAKE; i++) begin
      if (wv[i] && (wrd[i*LNCOMMIT +: LNCOMMIT] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sched_if
// Description : Op input, wakeup/kill and issue bundle of the ALU scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_sched_if;
  import alu_issue_sched_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [CNTRL_SIZE-1:0]     in_control;
  tag_t                      in_rd;
  logic                      in_makes_rd;
  logic                      in_needs_rs2;
  tag_t                      in_rs1;
  tag_t                      in_rs2;
  logic                      in_rs1_rdy;
  logic                      in_rs2_rdy;
  logic [31:0]               in_immed;
  logic [VA_SZ-2:0]          in_pc;
  logic [NWAKE-1:0]          wake_valid;
  logic [NWAKE*LNCOMMIT-1:0] wake_rd;
  logic [NCOMMIT-1:0]        commit_kill;
  logic                      issue_enable;
  logic [CNTRL_SIZE-1:0]     issue_control;
  tag_t                      issue_rd;
  logic                      issue_makes_rd;
  logic                      issue_needs_rs2;
  tag_t                      issue_rs1;
  tag_t                      issue_rs2;
  logic [31:0]               issue_immed;
  logic [VA_SZ-2:0]          issue_pc;
  logic [LNENT:0]            count;

  modport master (
    output in_valid, in_control, in_rd, in_makes_rd, in_needs_rs2,
           in_rs1, in_rs2, in_rs1_rdy, in_rs2_rdy, in_immed, in_pc,
           wake_valid, wake_rd, commit_kill,
    input  in_ready, issue_enable, issue_control, issue_rd, issue_makes_rd,
           issue_needs_rs2, issue_rs1, issue_rs2, issue_immed, issue_pc, count
  );

  modport slave (
    input  in_valid, in_control, in_rd, in_makes_rd, in_needs_rs2,
           in_rs1, in_rs2, in_rs1_rdy, in_rs2_rdy, in_immed, in_pc,
           wake_valid, wake_rd, commit_kill,
    output in_ready, issue_enable, issue_control, issue_rd, issue_makes_rd,
           issue_needs_rs2, issue_rs1, issue_rs2, issue_immed, issue_pc, count
  );

endinterface
`default_nettype wire

// File: rtl/alu_issue_sched_age_pick.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_age_pick
// Description : NENT x NENT age matrix with oldest-ready one-hot pick/encode.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_age_pick
  import alu_issue_sched_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc,
  input  idx_t            alloc_idx,
  input  logic [NENT-1:0] valid,
  input  logic [NENT-1:0] ready,
  output logic [NENT-1:0] sel_oh,
  output idx_t            sel_idx,
  output logic            any
);

  // r_age[i][j] set means entry j is older than entry i
  logic [NENT-1:0] r_age [NENT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NENT; i++) r_age[i] <= '0;
    end else if (alloc) begin
      // Stale column bits from the slot's previous occupant are cleared here
      for (int i = 0; i < NENT; i++) r_age[i][alloc_idx] <= 1'b0;
      r_age[alloc_idx] <= valid;
    end
  end

  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = 0; i < NENT; i++) begin
      sel_oh[i] = ready[i] & ~(|(r_age[i] & ready));
      if (sel_oh[i]) sel_idx = idx_t'(i);
    end
    any = |ready;
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sched
// Description : Out-of-order issue queue feeding one ALU; oldest-ready select.
//               Optional FAST_WAKEUP_EN: the selected op's rd wakes dependents
//               in its own select cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_sched
  import alu_issue_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  alu_issue_sched_if.slave  bus
);

  logic [NENT-1:0]       r_valid;
  entry_t                r_ent [NENT];
  cnt_t                  r_count;
  logic                  r_issue_en;
  logic [CNTRL_SIZE-1:0] r_issue_control;
  tag_t                  r_issue_rd;
  logic                  r_issue_makes_rd;
  logic                  r_issue_needs_rs2;
  tag_t                  r_issue_rs1;
  tag_t                  r_issue_rs2;
  logic [31:0]           r_issue_immed;
  logic [VA_SZ-2:0]      r_issue_pc;

  logic [NENT-1:0] w_ready, w_kill, w_sel_oh, w_valid_next;
  logic [NENT-1:0] w_rs1_hit, w_rs2_hit;
  idx_t            w_sel_idx, w_free_idx;
  logic            w_any, w_alloc, w_written;
  logic            w_fw_valid;
  tag_t            w_fw_rd;
  entry_t          w_sel, w_in_ent;

  assign bus.in_ready = (r_count != cnt_t'(NENT));

  always_comb begin
    w_ready = '0;
    w_kill  = '0;
    for (int i = 0; i < NENT; i++) begin
      w_kill[i]  = bus.commit_kill[r_ent[i].rd];
      w_ready[i] = r_valid[i] & r_ent[i].rs1_rdy &
                   (r_ent[i].rs2_rdy | ~r_ent[i].needs_rs2) & ~w_kill[i];
    end
  end

  alu_issue_age_pick u_age_pick (
    .clk       (clk),
    .reset     (reset),
    .alloc     (w_written),
    .alloc_idx (w_free_idx),
    .valid     (r_valid),
    .ready     (w_ready),
    .sel_oh    (w_sel_oh),
    .sel_idx   (w_sel_idx),
    .any       (w_any)
  );

  assign w_sel = r_ent[w_sel_idx];

`ifdef FAST_WAKEUP_EN
  assign w_fw_valid = w_any & w_sel.makes_rd;
  assign w_fw_rd    = w_sel.rd;
`else
  assign w_fw_valid = 1'b0;
  assign w_fw_rd    = '0;
`endif

  always_comb begin
    w_free_idx = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = idx_t'(i);
    end
  end

  // A killed incoming op is consumed but never lands in the queue
  assign w_alloc   = bus.in_valid & bus.in_ready;
  assign w_written = w_alloc & ~bus.commit_kill[bus.in_rd];

  always_comb begin
    w_rs1_hit = '0;
    w_rs2_hit = '0;
    for (int i = 0; i < NENT; i++) begin
      w_rs1_hit[i] = wake_hit(r_ent[i].rs1, bus.wake_valid, bus.wake_rd, w_fw_valid, w_fw_rd);
      w_rs2_hit[i] = wake_hit(r_ent[i].rs2, bus.wake_valid, bus.wake_rd, w_fw_valid, w_fw_rd);
    end
  end

  always_comb begin
    w_in_ent.control   = bus.in_control;
    w_in_ent.rd        = bus.in_rd;
    w_in_ent.makes_rd  = bus.in_makes_rd;
    w_in_ent.needs_rs2 = bus.in_needs_rs2;
    w_in_ent.rs1       = bus.in_rs1;
    w_in_ent.rs2       = bus.in_rs2;
    w_in_ent.rs1_rdy   = bus.in_rs1_rdy |
                         wake_hit(bus.in_rs1, bus.wake_valid, bus.wake_rd, w_fw_valid, w_fw_rd);
    w_in_ent.rs2_rdy   = bus.in_rs2_rdy |
                         wake_hit(bus.in_rs2, bus.wake_valid, bus.wake_rd, w_fw_valid, w_fw_rd);
    w_in_ent.immed     = bus.in_immed;
    w_in_ent.pc        = bus.in_pc;
  end

  always_comb begin
    w_valid_next = r_valid & ~w_sel_oh & ~w_kill;
    if (w_written) w_valid_next[w_free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        r_ent[i].rs1_rdy <= r_ent[i].rs1_rdy | w_rs1_hit[i];
        r_ent[i].rs2_rdy <= r_ent[i].rs2_rdy | w_rs2_hit[i];
      end
      if (w_written) r_ent[w_free_idx] <= w_in_ent;
      r_valid <= w_valid_next;
      r_count <= cnt_t'($countones(w_valid_next));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_en        <= 1'b0;
      r_issue_control   <= '0;
      r_issue_rd        <= '0;
      r_issue_makes_rd  <= 1'b0;
      r_issue_needs_rs2 <= 1'b0;
      r_issue_rs1       <= '0;
      r_issue_rs2       <= '0;
      r_issue_immed     <= '0;
      r_issue_pc        <= '0;
    end else begin
      r_issue_en <= w_any;
      if (w_any) begin
        r_issue_control   <= w_sel.control;
        r_issue_rd        <= w_sel.rd;
        r_issue_makes_rd  <= w_sel.makes_rd;
        r_issue_needs_rs2 <= w_sel.needs_rs2;
        r_issue_rs1       <= w_sel.rs1;
        r_issue_rs2       <= w_sel.rs2;
        r_issue_immed     <= w_sel.immed;
        r_issue_pc        <= w_sel.pc;
      end
    end
  end

  assign bus.issue_enable    = r_issue_en;
  assign bus.issue_control   = r_issue_control;
  assign bus.issue_rd        = r_issue_rd;
  assign bus.issue_makes_rd  = r_issue_makes_rd;
  assign bus.issue_needs_rs2 = r_issue_needs_rs2;
  assign bus.issue_rs1       = r_issue_rs1;
  assign bus.issue_rs2       = r_issue_rs2;
  assign bus.issue_immed     = r_issue_immed;
  assign bus.issue_pc        = r_issue_pc;
  assign bus.count           = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_sched
// Description : Directed + random bench for alu_issue_sched with an age-ordered
//               queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_sched_if bus_if ();

  alu_issue_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic [CNTRL_SIZE-1:0] control;
    tag_t                  rd;
    logic                  makes_rd;
    logic                  needs_rs2;
    tag_t                  rs1;
    tag_t                  rs2;
    logic                  r1;
    logic                  r2;
    logic [31:0]           immed;
    logic [VA_SZ-2:0]      pc;
  } mop_t;

  // Model queue is kept oldest-first
  mop_t q[$];
  mop_t exp_op;
  logic exp_en;
  int   tests = 0;
  int   fails = 0;
  int   edge_no = 0;
  logic loop_en = 1'b0;
  logic d1_v = 1'b0;
  tag_t d1_rd = '0;
  int   p_edge = -1;
  int   c_edge = -1;

`ifdef FAST_WAKEUP_EN
  localparam int B2B_GAP = 1;
`else
  localparam int B2B_GAP = 3;
`endif

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic bus_hit(input tag_t t, input logic fv, input tag_t frd);
    logic h;
    h = fv && (frd == t);
    for (int i = 0; i < NWAKE; i++)
      if (bus_if.wake_valid[i] && bus_if.wake_rd[i*LNCOMMIT +: LNCOMMIT] == t) h = 1'b1;
    return h;
  endfunction

  task automatic model_step();
    int   sel;
    logic fv;
    tag_t frd;
    mop_t nq[$];
    mop_t n;
    sel = -1;
    fv  = 1'b0;
    frd = '0;
    for (int i = 0; i < q.size(); i++)
      if (sel < 0 && q[i].r1 && (q[i].r2 || !q[i].needs_rs2) && !bus_if.commit_kill[q[i].rd])
        sel = i;
`ifdef FAST_WAKEUP_EN
    if (sel >= 0 && q[sel].makes_rd) begin
      fv  = 1'b1;
      frd = q[sel].rd;
    end
`endif
    for (int i = 0; i < q.size(); i++) begin
      if (i != sel && !bus_if.commit_kill[q[i].rd]) begin
        n = q[i];
        n.r1 = n.r1 | bus_hit(n.rs1, fv, frd);
        n.r2 = n.r2 | bus_hit(n.rs2, fv, frd);
        nq.push_back(n);
      end
    end
    if (bus_if.in_valid && q.size() != NENT && !bus_if.commit_kill[bus_if.in_rd]) begin
      n.control   = bus_if.in_control;
      n.rd        = bus_if.in_rd;
      n.makes_rd  = bus_if.in_makes_rd;
      n.needs_rs2 = bus_if.in_needs_rs2;
      n.rs1       = bus_if.in_rs1;
      n.rs2       = bus_if.in_rs2;
      n.r1        = bus_if.in_rs1_rdy | bus_hit(bus_if.in_rs1, fv, frd);
      n.r2        = bus_if.in_rs2_rdy | bus_hit(bus_if.in_rs2, fv, frd);
      n.immed     = bus_if.in_immed;
      n.pc        = bus_if.in_pc;
      nq.push_back(n);
    end
    exp_en = (sel >= 0);
    if (sel >= 0) exp_op = q[sel];
    q = nq;
  endtask

  task automatic cycle();
    logic cur_v;
    tag_t cur_rd;
    if (loop_en) begin
      bus_if.wake_valid[0]             = d1_v;
      bus_if.wake_rd[LNCOMMIT-1:0]     = d1_rd;
    end
    cur_v  = exp_en && exp_op.makes_rd;
    cur_rd = exp_op.rd;
    if (reset) begin
      q.delete();
      exp_en = 1'b0;
      exp_op = '{default: '0};
    end else begin
      model_step();
    end
    @(posedge clk);
    #1;
    edge_no++;
    d1_v  = cur_v && !reset;
    d1_rd = cur_rd;
    chk("count", 128'(bus_if.count), 128'(q.size()));
    chk("in_ready", 128'(bus_if.in_ready), 128'(q.size() != NENT));
    chk("issue_enable", 128'(bus_if.issue_enable), 128'(exp_en));
    chk("issue_fields",
        128'({bus_if.issue_control, bus_if.issue_rd, bus_if.issue_makes_rd, bus_if.issue_needs_rs2,
              bus_if.issue_rs1, bus_if.issue_rs2, bus_if.issue_immed, bus_if.issue_pc}),
        128'({exp_op.control, exp_op.rd, exp_op.makes_rd, exp_op.needs_rs2,
              exp_op.rs1, exp_op.rs2, exp_op.immed, exp_op.pc}));
    if (loop_en && bus_if.issue_enable) begin
      if (bus_if.issue_rd == 5'd10) p_edge = edge_no;
      if (bus_if.issue_rd == 5'd11) c_edge = edge_no;
    end
  endtask

  task automatic clear_in();
    bus_if.in_valid     = 1'b0;
    bus_if.wake_valid   = '0;
    bus_if.wake_rd      = '0;
    bus_if.commit_kill  = '0;
  endtask

  task automatic set_op(input tag_t rd, input tag_t rs1, input logic r1,
                        input tag_t rs2, input logic r2, input logic needs);
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    bus_if.in_valid     = 1'b1;
    bus_if.in_control   = CNTRL_SIZE'($urandom);
    bus_if.in_rd        = rd;
    bus_if.in_makes_rd  = 1'b1;
    bus_if.in_needs_rs2 = needs;
    bus_if.in_rs1       = rs1;
    bus_if.in_rs2       = rs2;
    bus_if.in_rs1_rdy   = r1;
    bus_if.in_rs2_rdy   = r2;
    bus_if.in_immed     = $urandom;
    bus_if.in_pc        = r64[VA_SZ-2:0];
  endtask

  task automatic push(input tag_t rd, input tag_t rs1, input logic r1,
                      input tag_t rs2, input logic r2, input logic needs);
    set_op(rd, rs1, r1, rs2, r2, needs);
    cycle();
    bus_if.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    exp_en = 1'b0;
    exp_op = '{default: '0};
    clear_in();
    set_op(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus_if.in_valid = 1'b0;

    // Reset and single op
    cycle();
    cycle();
    reset = 1'b0;
    chk("reset_count", 128'(bus_if.count), 128'd0);
    chk("reset_issue_pc", 128'(bus_if.issue_pc), 128'd0);
    push(5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    chk("single_count", 128'(bus_if.count), 128'd1);
    cycle();
    chk("single_en", 128'(bus_if.issue_enable), 128'd1);
    chk("single_rd", 128'(bus_if.issue_rd), 128'd3);
    chk("single_drain", 128'(bus_if.count), 128'd0);
    cycle();

    // Oldest first
    push(5'd1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    push(5'd2, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    push(5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("oldest_b", 128'(bus_if.issue_rd), 128'd2);
    cycle();
    chk("oldest_c", 128'(bus_if.issue_rd), 128'd4);
    bus_if.wake_valid[1] = 1'b1;
    bus_if.wake_rd[LNCOMMIT +: LNCOMMIT] = 5'd9;
    cycle();
    clear_in();
    cycle();
    chk("oldest_a", 128'(bus_if.issue_rd), 128'd1);
    cycle();

    // Full queue
    for (int k = 0; k < NENT; k++) push(tag_t'(12 + k), 5'd20, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("full_ready", 128'(bus_if.in_ready), 128'd0);
    push(5'd31, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("full_reject", 128'(bus_if.count), 128'(NENT));
    bus_if.wake_valid[0] = 1'b1;
    bus_if.wake_rd[LNCOMMIT-1:0] = 5'd20;
    cycle();
    clear_in();
    for (int k = 0; k < NENT; k++) begin
      cycle();
      chk("full_order", 128'(bus_if.issue_rd), 128'(12 + k));
    end
    cycle();

    // Kill
    push(5'd5, 5'd21, 1'b0, 5'd0, 1'b0, 1'b0);
    push(5'd6, 5'd21, 1'b0, 5'd0, 1'b0, 1'b0);
    bus_if.commit_kill[5] = 1'b1;
    cycle();
    clear_in();
    chk("kill_count", 128'(bus_if.count), 128'd1);
    bus_if.wake_valid[0] = 1'b1;
    bus_if.wake_rd[LNCOMMIT-1:0] = 5'd21;
    cycle();
    clear_in();
    cycle();
    chk("kill_survivor", 128'(bus_if.issue_rd), 128'd6);
    cycle();

    // Same-cycle wake on allocation
    bus_if.wake_valid[0] = 1'b1;
    bus_if.wake_rd[LNCOMMIT-1:0] = 5'd7;
    push(5'd8, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    clear_in();
    cycle();
    chk("alloc_wake_en", 128'(bus_if.issue_enable), 128'd1);
    chk("alloc_wake_rd", 128'(bus_if.issue_rd), 128'd8);
    cycle();

    // Back-to-back dependency with the ALU result looped onto wake bus 0
    loop_en = 1'b1;
    push(5'd10, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    push(5'd11, 5'd10, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (6) cycle();
    loop_en = 1'b0;
    clear_in();
    chk("b2b_gap", 128'(c_edge - p_edge), 128'(B2B_GAP));
    repeat (3) cycle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_op(tag_t'($urandom_range(0, 15)), tag_t'($urandom_range(0, 7)), 1'($urandom),
             tag_t'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      bus_if.in_valid     = 1'($urandom);
      bus_if.in_makes_rd  = 1'($urandom);
      bus_if.wake_valid   = NWAKE'($urandom);
      for (int w = 0; w < NWAKE; w++)
        bus_if.wake_rd[w*LNCOMMIT +: LNCOMMIT] = tag_t'($urandom_range(0, 7));
      bus_if.commit_kill = '0;
      if ($urandom_range(0, 7) == 0) bus_if.commit_kill[$urandom_range(0, 15)] = 1'b1;
      reset = (n == 200);
      cycle();
    end
    reset = 1'b0;
    clear_in();
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
